// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and a sticky divide-by-zero flag.
// Define MDU_MADD_EN to enable madd/maddu accumulation into {hi,lo}.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        dz
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;

    logic        multi;
    logic        is_div;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] prod;
    logic        sgn;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;

`ifdef MDU_MADD_EN
    logic [63:0] mac;
    assign multi = !(op == 3'b100 || op == 3'b101);
    assign mac   = {hi, lo} + prod;
`else
    assign multi = !op[2];
`endif

    assign is_div = (op[2:1] == 2'b01);
    assign busy   = (state == BUSY);

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'b0, a_q} * {32'b0, b_q};
    assign prod   = op_q[0] ? prod_u : prod_s;

    // Signed divide works on magnitudes, so INT_MIN / -1 wraps back to INT_MIN.
    assign sgn   = !op_q[0];
    assign a_neg = sgn & a_q[31];
    assign b_neg = sgn & b_q[31];
    assign a_mag = a_neg ? (~a_q + 32'd1) : a_q;
    assign b_mag = b_neg ? (~b_q + 32'd1) : b_q;
    assign q_mag = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
    assign r_mag = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
    assign quo   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem   = a_neg ? (~r_mag + 32'd1) : r_mag;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 5'd0;
            op_q  <= 3'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            dz    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (op == 3'b100) begin
                            hi <= A;
                        end else if (op == 3'b101) begin
                            lo <= A;
                        end else if (multi) begin
                            op_q  <= op;
                            a_q   <= A;
                            b_q   <= B;
                            cnt   <= is_div ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 5'd1) begin
                        state <= IDLE;
                        cnt   <= 5'd0;
                        case (op_q)
                            3'b000, 3'b001: {hi, lo} <= prod;
                            3'b010, 3'b011: begin
                                if (b_q == 32'd0) begin
                                    dz <= 1'b1;
                                end else begin
                                    hi <= rem;
                                    lo <= quo;
                                end
                            end
`ifdef MDU_MADD_EN
                            3'b110, 3'b111: {hi, lo} <= mac;
`endif
                            default: ;
                        endcase
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, giving busy duration of multiply ops in cycles (legal range 1..31).
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, giving busy duration of divide ops in cycles (legal range 1..31).
REQ-003 The block SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 The block SHALL have port start  in  1  op request, sampled on rising edge.
REQ-006 The block SHALL have port op  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 madd, 111 maddu.
REQ-007 The block SHALL have port A  in  32  first operand (rs), same source as ALU A.
REQ-008 The block SHALL have port B  in  32  second operand (rt), same source as ALU B.
REQ-009 The block SHALL have port busy  out  1  high while a multi-cycle op is in flight.
REQ-010 The block SHALL have port hi  out  32  HI register, driven directly from the flop.
REQ-011 The block SHALL have port lo  out  32  LO register, driven directly from the flop.
REQ-012 The block SHALL have port dz  out  1  sticky flag, set by div/divu with B==0.

Function
REQ-013 The FSM SHALL have two states, IDLE and BUSY; busy SHALL equal (state==BUSY).
REQ-014 In IDLE, start with op in {mult, multu, div, divu, madd, maddu} SHALL latch A, B and op, load the counter with MULT_CYCLES or DIV_CYCLES, and enter BUSY on the same edge.
REQ-015 In BUSY, the counter SHALL decrement once per cycle; on the edge where it reaches 1, the block SHALL write hi/lo and return to IDLE, giving exactly N busy cycles.
REQ-016 In IDLE, mthi/mtlo with start SHALL write hi=A or lo=A on that edge, with no busy cycle.
REQ-017 start while busy SHALL be ignored entirely: no latch, no hi/lo change, and the counter continues.
REQ-018 hi and lo SHALL hold their previous values throughout BUSY; operands latched at start SHALL be used, not live A/B.
REQ-019 mult SHALL form the signed 64-bit product and multu the unsigned 64-bit product, with {hi,lo} = product.
REQ-020 div/divu SHALL write lo=quotient and hi=remainder; the signed quotient SHALL truncate toward zero and the remainder SHALL take the sign of the dividend.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000.
REQ-022 Divide with B==0 SHALL still take DIV_CYCLES cycles, SHALL leave hi/lo unchanged, and SHALL set dz; dz SHALL clear only on reset.
REQ-023 The block SHALL take back-to-back ops: a start in the cycle busy falls (IDLE again) SHALL be accepted.

Reset
REQ-024 When reset==0 at a rising edge, the block SHALL set hi=0, lo=0, dz=0, busy=0 and state=IDLE, with the counter cleared.
REQ-025 Reset during BUSY SHALL abort the op with no hi/lo write; reset SHALL override a simultaneous start.

Configuration
REQ-026 With macro MDU_MADD_EN defined, madd SHALL compute {hi,lo} += signed A*B and maddu SHALL compute {hi,lo} += unsigned A*B, each taking MULT_CYCLES cycles with 64-bit wrap-around.
REQ-027 Without MDU_MADD_EN, op 110/111 SHALL be treated as no-op: no busy, and no hi/lo or dz change.

Verification
REQ-028 Reset low then high -> hi=0, lo=0, busy=0, dz=0.
REQ-029 mult with A=0xFFFFFFFF, B=0x00000002 -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-030 div with A=-7 (0xFFFFFFF9), B=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu with A=7, B=0 -> hi/lo unchanged, dz=1.
REQ-031 mult start, then start div with A changed on cycle 2 -> div ignored, mult result uses the original operands, busy for exactly 5 cycles.
REQ-032 mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive cycles -> hi=0x12345678, lo=0x9ABCDEF0, busy never high.
REQ-033 div start, reset low on busy cycle 4 -> busy=0 and hi=lo=0 next edge; with MDU_MADD_EN, hi=0, lo=0xFFFFFFFF, maddu A=1, B=1 -> hi=1, lo=0.
